// File: rtl/video_timing_gen_if.sv
// Raster output bundle of the video timing generator: data enable, syncs,
// RGB888 pixel data, pixel coordinates and the frame start pulse.
// The generator drives it through the master modport and the downstream
// video pipeline observes it through the slave modport.
interface video_timing_gen_if #(
  parameter int CW = 11
) ();
  logic          hdmi_de;
  logic          hdmi_hs;
  logic          hdmi_vs;
  logic [7:0]    hdmi_r;
  logic [7:0]    hdmi_g;
  logic [7:0]    hdmi_b;
  logic [CW-1:0] pix_x;
  logic [CW-1:0] pix_y;
  logic          frame_start;

  modport master (
    output hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b,
           pix_x, pix_y, frame_start
  );

  modport slave (
    input  hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b,
           pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised DVI/HDMI raster timing generator with run-time selectable
// RGB888 test patterns (solid, colour bars, gradient, checkerboard).
// Every output is registered, so the outputs for counter state (h,v)
// appear one cycle after the counters hold (h,v).
// Optional feature: define VTG_SCROLL_EN to add the frame_cnt output and
// scroll the bar, gradient and checker patterns one pixel per frame.
module video_timing_gen #(
  parameter int H_RES    = 64,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 2,
  parameter int H_BP     = 8,
  parameter int V_RES    = 64,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 8,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11,
  parameter int CHK_LOG2 = 3
) (
  input  logic              hdmi_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [23:0]       solid_rgb,
  video_timing_gen_if.master vid
`ifdef VTG_SCROLL_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_RES);
  localparam logic [CW-1:0] V_ACT    = CW'(V_RES);
  localparam logic [CW-1:0] HS_START = CW'(H_RES + H_FP);
  localparam logic [CW-1:0] HS_STOP  = CW'(H_RES + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_RES + V_FP);
  localparam logic [CW-1:0] VS_STOP  = CW'(V_RES + V_FP + V_SYNC);
  localparam logic [CW-1:0] X_LAST   = CW'(H_RES - 1);
  localparam logic [CW-1:0] BAR_LAST = CW'(H_RES / 8 - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // The last bar (index 7) never advances, so it absorbs the H_RES/8 remainder.
  function automatic logic [2:0] bar_step_idx(input logic [2:0] idx, input logic [CW-1:0] cnt);
    return (idx != 3'd7 && cnt == BAR_LAST) ? idx + 3'd1 : idx;
  endfunction

  function automatic logic [CW-1:0] bar_step_cnt(input logic [2:0] idx, input logic [CW-1:0] cnt);
    return (idx != 3'd7 && cnt == BAR_LAST) ? '0 : cnt + ONE;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   solid_q, solid_d;
  logic [CW-1:0] xs_q, xs_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [CW-1:0] bar_cnt_q, bar_cnt_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [CW-1:0] pix_x_q, pix_x_d;
  logic [CW-1:0] pix_y_q, pix_y_d;
  logic          fs_q, fs_d;

  logic          running;
  logic          h_wrap;
  logic          v_wrap;
  logic          f_wrap;
  logic          at_origin;
  logic          line_start;
  logic [1:0]    mode_cur;
  logic [23:0]   solid_cur;
  logic [CW-1:0] xs_cur;
  logic [2:0]    bar_idx_cur;
  logic [CW-1:0] bar_cnt_cur;
  logic [CW-1:0] scroll_x;
  logic [2:0]    scroll_idx;
  logic [CW-1:0] scroll_cnt;

  assign running    = (state_q != IDLE);
  assign h_wrap     = (hcnt_q == H_LAST);
  assign v_wrap     = (vcnt_q == V_LAST);
  assign f_wrap     = running && h_wrap && v_wrap;
  assign at_origin  = running && (hcnt_q == '0) && (vcnt_q == '0);
  assign line_start = (hcnt_q == '0);

  // Pattern controls take the live inputs at (0,0) so that pixel already uses them.
  assign mode_cur  = at_origin ? mode : mode_q;
  assign solid_cur = at_origin ? solid_rgb : solid_q;

  // Each line restarts the pattern x and bar tracker at the current scroll offset.
  assign xs_cur      = line_start ? scroll_x   : xs_q;
  assign bar_idx_cur = line_start ? scroll_idx : bar_idx_q;
  assign bar_cnt_cur = line_start ? scroll_cnt : bar_cnt_q;

`ifdef VTG_SCROLL_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] scroll_x_q, scroll_x_d;
  logic [2:0]    scroll_idx_q, scroll_idx_d;
  logic [CW-1:0] scroll_cnt_q, scroll_cnt_d;

  // Advance the frame count and its mod-H_RES image (with bar position) at every frame wrap.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    scroll_x_d   = scroll_x_q;
    scroll_idx_d = scroll_idx_q;
    scroll_cnt_d = scroll_cnt_q;
    if (f_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (frame_cnt_q == 16'hFFFF || scroll_x_q == X_LAST) begin
        scroll_x_d   = '0;
        scroll_idx_d = '0;
        scroll_cnt_d = '0;
      end else begin
        scroll_x_d   = scroll_x_q + ONE;
        scroll_idx_d = bar_step_idx(scroll_idx_q, scroll_cnt_q);
        scroll_cnt_d = bar_step_cnt(scroll_idx_q, scroll_cnt_q);
      end
    end
  end

  // Scroll state registers.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      scroll_x_q   <= '0;
      scroll_idx_q <= '0;
      scroll_cnt_q <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      scroll_x_q   <= scroll_x_d;
      scroll_idx_q <= scroll_idx_d;
      scroll_cnt_q <= scroll_cnt_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign scroll_x   = scroll_x_q;
  assign scroll_idx = scroll_idx_q;
  assign scroll_cnt = scroll_cnt_q;
`else
  assign scroll_x   = '0;
  assign scroll_idx = '0;
  assign scroll_cnt = '0;
`endif

  // Next state: run control, raster counters, pattern trackers and decoded outputs.
  always_comb begin
    logic        active;
    logic        hs_act;
    logic        vs_act;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic [23:0] pat;

    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    xs_d      = xs_q;
    bar_idx_d = bar_idx_q;
    bar_cnt_d = bar_cnt_q;
    mode_d    = mode_cur;
    solid_d   = solid_cur;

    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (f_wrap)   state_d = en ? RUN : IDLE;
        else if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        if (f_wrap) state_d = en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (running) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + ONE;
      if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + ONE;
      if (xs_cur == X_LAST) begin
        xs_d      = '0;
        bar_idx_d = '0;
        bar_cnt_d = '0;
      end else begin
        xs_d      = xs_cur + ONE;
        bar_idx_d = bar_step_idx(bar_idx_cur, bar_cnt_cur);
        bar_cnt_d = bar_step_cnt(bar_idx_cur, bar_cnt_cur);
      end
    end

    active = running && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_act = running && (hcnt_q >= HS_START) && (hcnt_q < HS_STOP);
    vs_act = running && (vcnt_q >= VS_START) && (vcnt_q < VS_STOP);

    x8 = xs_cur[7:0];
    y8 = vcnt_q[7:0];
    case (mode_cur)
      2'd0:    pat = solid_cur;
      2'd1:    pat = bar_colour(bar_idx_cur);
      2'd2:    pat = {x8, y8, x8 + y8};
      default: pat = (xs_cur[CHK_LOG2] ^ vcnt_q[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
    endcase

    de_d    = active;
    hs_d    = hs_act ? HS_ON : ~HS_ON;
    vs_d    = vs_act ? VS_ON : ~VS_ON;
    rgb_d   = active ? pat : 24'h000000;
    pix_x_d = active ? hcnt_q : '0;
    pix_y_d = active ? vcnt_q : '0;
    fs_d    = active && at_origin;
  end

  // Run-control FSM together with every counter and registered output.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
      xs_q      <= '0;
      bar_idx_q <= '0;
      bar_cnt_q <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~HS_ON;
      vs_q      <= ~VS_ON;
      rgb_q     <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      xs_q      <= xs_d;
      bar_idx_q <= bar_idx_d;
      bar_cnt_q <= bar_cnt_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      fs_q      <= fs_d;
    end
  end

  assign vid.hdmi_de     = de_q;
  assign vid.hdmi_hs     = hs_q;
  assign vid.hdmi_vs     = vs_q;
  assign vid.hdmi_r      = rgb_q[23:16];
  assign vid.hdmi_g      = rgb_q[15:8];
  assign vid.hdmi_b      = rgb_q[7:0];
  assign vid.pix_x       = pix_x_q;
  assign vid.pix_y       = pix_y_q;
  assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed testbench for video_timing_gen: default-parameter instance for
// raster timing, patterns, drain and reset, plus an HS/VS active-high
// instance with H_RES=70 for polarity and last-bar remainder.
module tb_video_timing_gen;

  logic        hdmi_clk;
  logic        rst_n;
  logic        en1, en2;
  logic [1:0]  mode1, mode2;
  logic [23:0] solid1, solid2;
`ifdef VTG_SCROLL_EN
  logic [15:0] fc1, fc2;
`endif

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  video_timing_gen_if #(.CW(11)) vid1 ();
  video_timing_gen_if #(.CW(11)) vid2 ();

  video_timing_gen u_dut1 (
    .hdmi_clk  (hdmi_clk),
    .rst_n     (rst_n),
    .en        (en1),
    .mode      (mode1),
    .solid_rgb (solid1),
    .vid       (vid1)
`ifdef VTG_SCROLL_EN
    ,
    .frame_cnt (fc1)
`endif
  );

  video_timing_gen #(
    .H_RES  (70),
    .HS_POL (1),
    .VS_POL (1)
  ) u_dut2 (
    .hdmi_clk  (hdmi_clk),
    .rst_n     (rst_n),
    .en        (en2),
    .mode      (mode2),
    .solid_rgb (solid2),
    .vid       (vid2)
`ifdef VTG_SCROLL_EN
    ,
    .frame_cnt (fc2)
`endif
  );

  // Pixel clock, period 10; outputs are sampled on the falling edge.
  initial hdmi_clk = 1'b0;
  always #5 hdmi_clk = ~hdmi_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Step falling edges until the frame-relative cycle index reaches t.
  task automatic goto_idx(input int t);
    while (cur < t) begin
      @(negedge hdmi_clk);
      cur++;
    end
  endtask

  // Count falling edges until frame_start of the selected instance, bounded.
  task automatic wait_fs(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge hdmi_clk);
      n++;
    end while (!(sel ? vid2.frame_start : vid1.frame_start) && n < 20);
  endtask

  // Walk one full default frame of instance 1 starting at its frame_start cycle.
  task automatic measure_frame(output int de_n, output int hs_n, output int vs_n, output int fs_n,
                               output int de_fall, output int hs_fall, output int de_rise,
                               output int vs_fall);
    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0;
    de_fall = -1; hs_fall = -1; de_rise = -1; vs_fall = -1;
    for (int i = 0; i < 6888; i++) begin
      if (i > 0) @(negedge hdmi_clk);
      if (vid1.hdmi_de) begin
        de_n++;
        if (de_fall >= 0 && de_rise < 0) de_rise = i;
      end else if (de_fall < 0) begin
        de_fall = i;
      end
      if (!vid1.hdmi_hs) begin
        hs_n++;
        if (hs_fall < 0) hs_fall = i;
      end
      if (!vid1.hdmi_vs) begin
        vs_n++;
        if (vs_fall < 0) vs_fall = i;
      end
      if (vid1.frame_start) fs_n++;
    end
    @(negedge hdmi_clk);
  endtask

  function automatic logic [23:0] rgb1();
    return {vid1.hdmi_r, vid1.hdmi_g, vid1.hdmi_b};
  endfunction

  function automatic logic [23:0] rgb2();
    return {vid2.hdmi_r, vid2.hdmi_g, vid2.hdmi_b};
  endfunction

  initial begin
    int n;
    int de_n, hs_n, vs_n, fs_n, de_fall, hs_fall, de_rise, vs_fall;
    int bad;
    int bar_x [10];
    logic [23:0] bar_c [10];

    bar_x = '{0, 7, 8, 16, 24, 32, 40, 48, 56, 63};
    bar_c = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};

    rst_n  = 1'b0;
    en1    = 1'b0;
    en2    = 1'b0;
    mode1  = 2'd0;
    mode2  = 2'd0;
    solid1 = 24'h123456;
    solid2 = 24'h000000;

    // Reset values of both instances.
    #22;
    check_output("rst_de",    32'(vid1.hdmi_de), 32'd0);
    check_output("rst_hs",    32'(vid1.hdmi_hs), 32'd1);
    check_output("rst_vs",    32'(vid1.hdmi_vs), 32'd1);
    check_output("rst_rgb",   32'(rgb1()), 32'h0);
    check_output("rst_px",    32'(vid1.pix_x), 32'd0);
    check_output("rst_py",    32'(vid1.pix_y), 32'd0);
    check_output("rst_fs",    32'(vid1.frame_start), 32'd0);
    check_output("rst_hs_p1", 32'(vid2.hdmi_hs), 32'd0);
    check_output("rst_vs_p1", 32'(vid2.hdmi_vs), 32'd0);

    // Release with en=1: first frame_start two cycles later, solid colour.
    @(negedge hdmi_clk);
    rst_n = 1'b1;
    en1   = 1'b1;
    wait_fs(1'b0, n);
    check_output("start_lat", 32'(n), 32'd2);
    check_output("f1_rgb00",  32'(rgb1()), 32'h123456);
    check_output("f1_de00",   32'(vid1.hdmi_de), 32'd1);
    check_output("f1_px00",   32'(vid1.pix_x), 32'd0);
    check_output("f1_py00",   32'(vid1.pix_y), 32'd0);

    // Whole-frame timing measurement.
    measure_frame(de_n, hs_n, vs_n, fs_n, de_fall, hs_fall, de_rise, vs_fall);
    check_output("de_count",  32'(de_n), 32'd4096);
    check_output("hs_count",  32'(hs_n), 32'd168);
    check_output("vs_count",  32'(vs_n), 32'd328);
    check_output("fs_count",  32'(fs_n), 32'd1);
    check_output("de_fall",   32'(de_fall), 32'd64);
    check_output("hs_fall",   32'(hs_fall), 32'd72);
    check_output("line_per",  32'(de_rise), 32'd82);
    check_output("vs_fall",   32'(vs_fall), 32'd5904);
    check_output("frame_per", 32'(vid1.frame_start), 32'd1);
    check_output("f2_rgb00",  32'(rgb1()), 32'h123456);
    cur = 0;

    // Mid-frame changes of solid_rgb/mode must not take effect until (0,0).
    goto_idx(200);
    solid1 = 24'hABCDEF;
    mode1  = 2'd2;
    goto_idx(300);
    check_output("midframe_hold", 32'(rgb1()), 32'h123456);
    goto_idx(6888);
    check_output("f3_fs", 32'(vid1.frame_start), 32'd1);
    cur = 0;

    // Gradient.
    check_output("grad_00",    32'(rgb1()), 32'h000000);
    goto_idx(64);
    check_output("blank_de",   32'(vid1.hdmi_de), 32'd0);
    check_output("blank_rgb",  32'(rgb1()), 32'h0);
    goto_idx(251);
    check_output("grad_53",    32'(rgb1()), 32'h050308);
    check_output("grad_53_px", 32'(vid1.pix_x), 32'd5);
    check_output("grad_53_py", 32'(vid1.pix_y), 32'd3);
    goto_idx(5229);
    check_output("grad_6363",  32'(rgb1()), 32'h3F3F7E);
    mode1 = 2'd3;
    goto_idx(6888);
    check_output("f4_fs", 32'(vid1.frame_start), 32'd1);
    cur = 0;

    // Checkerboard.
    check_output("chk_00", 32'(rgb1()), 32'h000000);
    goto_idx(8);
    check_output("chk_80", 32'(rgb1()), 32'hFFFFFF);
    goto_idx(656);
    check_output("chk_08", 32'(rgb1()), 32'hFFFFFF);
    goto_idx(664);
    check_output("chk_88", 32'(rgb1()), 32'h000000);
    mode1 = 2'd1;
    goto_idx(6888);
    check_output("f5_fs", 32'(vid1.frame_start), 32'd1);
    cur = 0;

    // Colour bars on line 0.
    for (int k = 0; k < 10; k++) begin
      goto_idx(bar_x[k]);
      check_output($sformatf("bar_x%0d", bar_x[k]), 32'(rgb1()), 32'(bar_c[k]));
    end
    goto_idx(64);
    check_output("bar_blank", 32'(rgb1()), 32'h0);

    // Drop en at pixel (10,20): the frame still completes.
    goto_idx(1650);
    check_output("drop_px", 32'(vid1.pix_x), 32'd10);
    check_output("drop_py", 32'(vid1.pix_y), 32'd20);
    en1  = 1'b0;
    de_n = 0;
    fs_n = 0;
    while (cur < 6887) begin
      @(negedge hdmi_clk);
      cur++;
      if (vid1.hdmi_de) de_n++;
      if (vid1.frame_start) fs_n++;
    end
    check_output("drain_de",  32'(de_n), 32'd2805);
    check_output("drain_fs",  32'(fs_n), 32'd0);
    @(negedge hdmi_clk);
    check_output("idle_de",   32'(vid1.hdmi_de), 32'd0);
    check_output("idle_fs",   32'(vid1.frame_start), 32'd0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (vid1.hdmi_de || !vid1.hdmi_hs || !vid1.hdmi_vs || vid1.frame_start || rgb1() != 24'h0)
        bad++;
      @(negedge hdmi_clk);
    end
    check_output("idle_quiet", 32'(bad), 32'd0);

    // Restore en: frame_start exactly two cycles later.
    en1 = 1'b1;
    wait_fs(1'b0, n);
    check_output("restart_lat", 32'(n), 32'd2);
    cur = 0;

    // Asynchronous reset mid-line.
    goto_idx(30);
    check_output("pre_rst_de", 32'(vid1.hdmi_de), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_de",  32'(vid1.hdmi_de), 32'd0);
    check_output("async_rgb", 32'(rgb1()), 32'h0);
    check_output("async_px",  32'(vid1.pix_x), 32'd0);
    check_output("async_hs",  32'(vid1.hdmi_hs), 32'd1);
    @(negedge hdmi_clk);
    rst_n = 1'b1;
    wait_fs(1'b0, n);
    check_output("post_rst_lat", 32'(n), 32'd2);
    check_output("post_rst_px",  32'(vid1.pix_x), 32'd0);
    check_output("post_rst_py",  32'(vid1.pix_y), 32'd0);
    en1 = 1'b0;

    // Active-high syncs, H_RES=70 colour bars.
    @(negedge hdmi_clk);
    mode2 = 2'd1;
    en2   = 1'b1;
    wait_fs(1'b1, n);
    check_output("p1_start_lat", 32'(n), 32'd2);
    cur = 0;
    check_output("p1_hs_idle", 32'(vid2.hdmi_hs), 32'd0);
    check_output("p1_vs_idle", 32'(vid2.hdmi_vs), 32'd0);
    check_output("p1_bar_x0",  32'(rgb2()), 32'hFFFFFF);
    goto_idx(40);
    check_output("p1_bar_x40", 32'(rgb2()), 32'hFF0000);
    goto_idx(60);
    check_output("p1_bar_x60", 32'(rgb2()), 32'h000000);
    goto_idx(69);
    check_output("p1_bar_x69", 32'(rgb2()), 32'h000000);
    check_output("p1_de_x69",  32'(vid2.hdmi_de), 32'd1);
    goto_idx(70);
    check_output("p1_de_x70",  32'(vid2.hdmi_de), 32'd0);
    goto_idx(77);
    check_output("p1_hs_77",   32'(vid2.hdmi_hs), 32'd0);
    goto_idx(78);
    check_output("p1_hs_78",   32'(vid2.hdmi_hs), 32'd1);
    goto_idx(79);
    check_output("p1_hs_79",   32'(vid2.hdmi_hs), 32'd1);
    goto_idx(80);
    check_output("p1_hs_80",   32'(vid2.hdmi_hs), 32'd0);
    goto_idx(6335);
    check_output("p1_vs_pre",  32'(vid2.hdmi_vs), 32'd0);
    goto_idx(6336);
    check_output("p1_vs_on",   32'(vid2.hdmi_vs), 32'd1);
    goto_idx(6687);
    check_output("p1_vs_last", 32'(vid2.hdmi_vs), 32'd1);
    goto_idx(6688);
    check_output("p1_vs_off",  32'(vid2.hdmi_vs), 32'd0);
    goto_idx(7392);
    check_output("p1_frame_per", 32'(vid2.frame_start), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
